sb_rx_deserializer: RTL and testbench

//  Sideband receive stage: the line-side counterpart of the sideband serializer on the same 800MHz clock.

---
 rtl/sb_pkg.sv | 18 +
 rtl/sb_rx_fifo.sv | 59 +++++
 rtl/sb_rx_deserializer.sv | 92 +++++++++
 tb/tb_sb_rx_deserializer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - sideband receive constants, state encoding and forwarded-clock pattern helper
package sb_pkg;

    localparam int SB_PKT_W   = 64;
    localparam int SB_GAP_MIN = 31;
    localparam int SB_CTR_W   = $clog2(SB_PKT_W);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } rx_state_t;

    // Forwarded clock is high on even bits and on the final bit, low on odd bits 1..61.
    function automatic logic sb_exp_clk(input logic [SB_CTR_W-1:0] bit_idx);
        return !bit_idx[0] || (bit_idx == SB_CTR_W'(SB_PKT_W - 1));
    endfunction

endpackage

// File: rtl/sb_rx_fifo.sv
// rtl/sb_rx_fifo.sv - small registered FIFO holding received sideband packets
module sb_rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 64
) (
    input  logic                          clk_800MHz,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              push_data,
    output logic [WIDTH-1:0]              head_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop    = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_800MHz) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_800MHz) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sb_rx_deserializer.sv
// rtl/sb_rx_deserializer.sv - sideband line receiver: start detect, framing check, packet buffering
module sb_rx_deserializer
    import sb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_800MHz,
    input  logic                reset,
    input  logic                dataPin_i,
    input  logic                clkPin_i,
    input  logic                enable_i,
    output logic [SB_PKT_W-1:0] data_o,
    output logic                valid_o,
    input  logic                ack_i,
    output logic                overflow_o,
    output logic                frame_err_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rx_state_t             state;
    logic [SB_CTR_W-1:0]   bit_ctr;
    logic                  clk_q;
    logic [SB_PKT_W-2:0]   shreg;
    logic                  clk_ok;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic [CNT_W-1:0]      fifo_count;
    logic [SB_PKT_W-1:0]   pkt;

    assign clk_ok  = (clkPin_i == sb_exp_clk(bit_ctr));
    assign push    = (state == RECEIVE) && (bit_ctr == SB_CTR_W'(SB_PKT_W - 1)) && clk_ok;
    assign pkt     = {dataPin_i, shreg};
    assign valid_o = (fifo_count != '0);
    assign pop     = ack_i && valid_o;

    // LSB-first shift: after bits 0..62 have entered, bit 0 sits at shreg[0].
    always_ff @(posedge clk_800MHz) begin
        if (reset) begin
            state       <= IDLE;
            bit_ctr     <= '0;
            clk_q       <= 1'b0;
            shreg       <= '0;
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            clk_q       <= clkPin_i;
            overflow_o  <= push && fifo_full && !pop;
            frame_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Two clock-high samples in a row only occur at a packet start.
                    if (enable_i && clk_q && clkPin_i) begin
                        shreg   <= {dataPin_i, shreg[SB_PKT_W-2:1]};
                        bit_ctr <= SB_CTR_W'(1);
                        state   <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    shreg <= {dataPin_i, shreg[SB_PKT_W-2:1]};
                    if (!clk_ok) begin
                        frame_err_o <= 1'b1;
                        bit_ctr     <= '0;
                        state       <= IDLE;
                    end else if (bit_ctr == SB_CTR_W'(SB_PKT_W - 1)) begin
                        bit_ctr <= '0;
                        state   <= IDLE;
                    end else begin
                        bit_ctr <= bit_ctr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sb_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (SB_PKT_W)
    ) u_fifo (
        .clk_800MHz (clk_800MHz),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_data  (pkt),
        .head_data  (data_o),
        .full       (fifo_full),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_sb_rx_deserializer.sv
// tb/tb_sb_rx_deserializer.sv - directed self-checking bench for sb_rx_deserializer
module tb_sb_rx_deserializer;
    import sb_pkg::*;

    logic        clk_800MHz = 1'b0;
    logic        reset      = 1'b1;
    logic        dataPin_i  = 1'b0;
    logic        clkPin_i   = 1'b0;
    logic        enable_i   = 1'b0;
    logic        ack_i      = 1'b0;
    logic [63:0] data_o;
    logic        valid_o;
    logic        overflow_o;
    logic        frame_err_o;

    int          checks = 0;
    int          errors = 0;
    logic        valid_before_last;
    logic        seen;
    logic [63:0] pk [6];
    logic [63:0] d;

    sb_rx_deserializer #(.FIFO_DEPTH(4)) dut (
        .clk_800MHz  (clk_800MHz),
        .reset       (reset),
        .dataPin_i   (dataPin_i),
        .clkPin_i    (clkPin_i),
        .enable_i    (enable_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ack_i       (ack_i),
        .overflow_o  (overflow_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk_800MHz = ~clk_800MHz;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_800MHz);
        #1;
    endtask

    task automatic idle(input int n);
        dataPin_i = 1'b0;
        clkPin_i  = 1'b0;
        repeat (n) step();
    endtask

    // Toggling gap starting low; odd lengths end low so the next start is clean.
    task automatic gap(input int n);
        for (int g = 0; g < n; g++) begin
            dataPin_i = 1'b0;
            clkPin_i  = (g % 2) == 1;
            step();
        end
    endtask

    task automatic send_frame(input logic [63:0] pkt, input int n_bits,
                              input bit corrupt_last, input bit ack_last);
        dataPin_i = 1'b0;
        clkPin_i  = 1'b1;
        step();
        for (int k = 0; k < n_bits; k++) begin
            dataPin_i = pkt[k];
            clkPin_i  = (k == 0) || (k == 63) || ((k % 2) == 0);
            if (corrupt_last && k == n_bits - 1) clkPin_i = ~clkPin_i;
            if (k == 63) begin
                valid_before_last = valid_o;
                if (ack_last) ack_i = 1'b1;
            end
            step();
        end
        if (ack_last) ack_i = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [63:0] exp);
        dataPin_i = 1'b0;
        clkPin_i  = 1'b0;
        chk1({tag, "_valid"}, valid_o, 1'b1);
        chk64({tag, "_data"}, data_o, exp);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
    endtask

    initial begin
        pk[0] = 64'h1111_2222_3333_4444;
        pk[1] = 64'h8000_0000_0000_0001;
        pk[2] = 64'hAAAA_5555_AAAA_5555;
        pk[3] = 64'h0F0F_F0F0_0F0F_F0F0;
        pk[4] = 64'hFEDC_BA98_7654_3210;
        pk[5] = 64'h1234_5678_9ABC_DEF0;

        // Reset state
        step();
        step();
        chk1("rst_valid", valid_o, 1'b0);
        chk64("rst_data", data_o, 64'h0);
        chk1("rst_ovf", overflow_o, 1'b0);
        chk1("rst_ferr", frame_err_o, 1'b0);
        reset    = 1'b0;
        enable_i = 1'b1;
        idle(3);

        // 1: single packet, latency and pop
        send_frame(64'hDEAD_BEEF_0123_4567, 64, 1'b0, 1'b0);
        chk1("t1_valid_before", valid_before_last, 1'b0);
        chk1("t1_valid", valid_o, 1'b1);
        chk64("t1_data", data_o, 64'hDEAD_BEEF_0123_4567);
        ack_i = 1'b1;
        idle(1);
        ack_i = 1'b0;
        chk1("t1_valid_after_ack", valid_o, 1'b0);
        chk64("t1_data_after_ack", data_o, 64'h0);
        gap(SB_GAP_MIN);

        // 2: fill with gaps, overflow, then pop during the completing push
        for (int i = 0; i < 4; i++) begin
            send_frame(pk[i], 64, 1'b0, 1'b0);
            gap(SB_GAP_MIN);
        end
        chk1("t2_valid_full", valid_o, 1'b1);
        chk64("t2_head_full", data_o, pk[0]);
        send_frame(pk[4], 64, 1'b0, 1'b0);
        chk1("t2_ovf_pulse", overflow_o, 1'b1);
        chk1("t2_ferr_quiet", frame_err_o, 1'b0);
        chk64("t2_head_after_drop", data_o, pk[0]);
        idle(1);
        chk1("t2_ovf_cleared", overflow_o, 1'b0);
        gap(SB_GAP_MIN);
        send_frame(pk[5], 64, 1'b0, 1'b1);
        chk1("t2_no_ovf_with_pop", overflow_o, 1'b0);
        chk64("t2_head_after_pop", data_o, pk[1]);
        pop_check("t2_pop1", pk[1]);
        pop_check("t2_pop2", pk[2]);
        pop_check("t2_pop3", pk[3]);
        pop_check("t2_pop5", pk[5]);
        chk1("t2_empty", valid_o, 1'b0);
        idle(2);

        // 3: clock held low at bit 10, then recovery
        send_frame(64'h0123_4567_89AB_CDEF, 11, 1'b1, 1'b0);
        chk1("t3_ferr_pulse", frame_err_o, 1'b1);
        chk1("t3_valid_low", valid_o, 1'b0);
        idle(1);
        chk1("t3_ferr_cleared", frame_err_o, 1'b0);
        idle(3);
        send_frame(64'h1, 64, 1'b0, 1'b0);
        chk1("t3_rec_valid", valid_o, 1'b1);
        chk64("t3_rec_data", data_o, 64'h1);
        chk1("t3_rec_ferr", frame_err_o, 1'b0);
        pop_check("t3_pop", 64'h1);
        chk1("t3_empty", valid_o, 1'b0);
        idle(2);

        // 4: isolated pulses, toggle train, disabled receiver
        seen = 1'b0;
        for (int r = 0; r < 4; r++) begin
            dataPin_i = 1'b1;
            clkPin_i  = 1'b1;
            step();
            seen = seen | valid_o | frame_err_o | overflow_o;
            dataPin_i = 1'b0;
            clkPin_i  = 1'b0;
            step();
            seen = seen | valid_o | frame_err_o | overflow_o;
            step();
            seen = seen | valid_o | frame_err_o | overflow_o;
        end
        for (int g = 0; g < 32; g++) begin
            dataPin_i = 1'b0;
            clkPin_i  = (g % 2) == 0;
            step();
            seen = seen | valid_o | frame_err_o | overflow_o;
        end
        idle(3);
        seen = seen | valid_o | frame_err_o | overflow_o;
        chk1("t4_no_activity", seen, 1'b0);
        enable_i = 1'b0;
        send_frame(64'hCAFE_F00D_1357_9BDF, 64, 1'b0, 1'b0);
        chk1("t4_disabled_valid", valid_o, 1'b0);
        chk1("t4_disabled_ferr", frame_err_o, 1'b0);
        enable_i = 1'b1;
        idle(2);
        chk1("t4_disabled_valid_late", valid_o, 1'b0);

        // 5: reset mid-packet clears buffered data, next packet intact
        send_frame(64'h5A5A_A5A5_C3C3_3C3C, 64, 1'b0, 1'b0);
        chk1("t5_pre_valid", valid_o, 1'b1);
        idle(2);
        send_frame(64'h0000_FFFF_0000_FFFF, 40, 1'b0, 1'b0);
        dataPin_i = 1'b1;
        clkPin_i  = 1'b1;
        reset     = 1'b1;
        step();
        chk1("t5_rst_valid", valid_o, 1'b0);
        chk64("t5_rst_data", data_o, 64'h0);
        chk1("t5_rst_ovf", overflow_o, 1'b0);
        chk1("t5_rst_ferr", frame_err_o, 1'b0);
        reset = 1'b0;
        idle(3);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, 1'b0);
        chk64("t5_ones_data", data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        pop_check("t5_pop", 64'hFFFF_FFFF_FFFF_FFFF);
        chk1("t5_empty", valid_o, 1'b0);
        idle(2);

        // 6: push+pop at count 2, then pointer wrap with continuous ack
        send_frame(pk[2], 64, 1'b0, 1'b0);
        idle(2);
        send_frame(pk[3], 64, 1'b0, 1'b0);
        idle(2);
        send_frame(pk[4], 64, 1'b0, 1'b1);
        chk64("t6_head_after_pp", data_o, pk[3]);
        chk1("t6_no_ovf", overflow_o, 1'b0);
        pop_check("t6_pop3", pk[3]);
        pop_check("t6_pop4", pk[4]);
        chk1("t6_empty", valid_o, 1'b0);
        idle(2);
        ack_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = 64'h0123_4567_89AB_CDEF ^ ({32'h0, 32'(i)} * 64'h1111_1111_1111_1111);
            send_frame(d, 64, 1'b0, 1'b0);
            chk1("t6_wrap_valid", valid_o, 1'b1);
            chk64("t6_wrap_data", data_o, d);
            idle(1);
            chk1("t6_wrap_drained", valid_o, 1'b0);
            idle(1);
        end
        ack_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
